updown_counter_gen: RTL and testbench

//   Parametrised up/down counter: next generation of the 8-bit up/down counter.
//   - Adds configurable width, modulus (MAX_COUNT), step size, and a synchronous load.
//   - Adds a choice of wrap or saturate at the bounds, plus wrap/limit status flags.
//   - Used as the general-purpose event/position counter in the exercise designs.
//

---
 rtl/updown_counter_gen_pkg.sv | 17 +
 rtl/updown_counter_gen_if.sv | 33 +++
 rtl/updown_counter_gen_next_calc.sv | 57 +++++
 rtl/updown_counter_gen.sv | 82 ++++++++
 tb/tb_updown_counter_gen.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/updown_counter_gen_pkg.sv
// Shared encodings for the up/down counter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: direction and bound-mode encodings used by the top and next-value calculator.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/updown_counter_gen_if.sv
// Control/status bundle between a counter user and updown_counter_gen.
// Latency: n/a (wiring only).
// Backpressure: none; the counter accepts a command every cycle.
// Signals: enable, direction, step, load, load_value, clear_flags (to counter);
//          counter_out, wrap, ovf_sticky, at_max, at_min (from counter).
interface updown_counter_gen_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);

  logic              enable;
  logic              direction;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_value;
  logic              clear_flags;
  logic [WIDTH-1:0]  counter_out;
  logic              wrap;
  logic              ovf_sticky;
  logic              at_max;
  logic              at_min;

  modport master (
    output enable, direction, step, load, load_value, clear_flags,
    input  counter_out, wrap, ovf_sticky, at_max, at_min
  );

  modport slave (
    input  enable, direction, step, load, load_value, clear_flags,
    output counter_out, wrap, ovf_sticky, at_max, at_min
  );

endinterface

// File: rtl/updown_counter_gen_next_calc.sv
// Next-count calculator: applies one up/down step with wrap or clamp at 0..MAX_COUNT.
// Latency: combinational.
// Backpressure: none.
// Ports: i_count, i_step, i_direction, i_mode in; o_next (next value), o_crossed (bound hit) out.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255,
  parameter int STEP_W    = 4
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic [STEP_W-1:0] i_step,
  input  dir_e              i_direction,
  input  mode_e             i_mode,
  output logic [WIDTH-1:0]  o_next,
  output logic              o_crossed
);

  // Bound compares use one extra bit so count+step cannot truncate before the test.
  localparam logic [WIDTH:0]   LP_MAX_WIDE = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] LP_MAX      = WIDTH'(MAX_COUNT);
  // Modulus taken mod 2**WIDTH: every result lies in 0..MAX_COUNT, so
  // WIDTH-bit modular arithmetic gives the exact value even when MAX_COUNT+1 == 2**WIDTH.
  localparam logic [WIDTH-1:0] LP_MOD      = WIDTH'(MAX_COUNT + 1);

  logic [WIDTH:0]   w_count_wide;
  logic [WIDTH:0]   w_step_wide;
  logic [WIDTH:0]   w_sum_wide;
  logic [WIDTH-1:0] w_step_n;

  assign w_count_wide = {1'b0, i_count};
  assign w_step_wide  = (WIDTH+1)'(i_step);
  assign w_sum_wide   = w_count_wide + w_step_wide;
  assign w_step_n     = WIDTH'(i_step);

  always_comb begin
    o_next    = i_count;
    o_crossed = 1'b0;
    if (i_direction == DIR_UP) begin
      if (w_sum_wide > LP_MAX_WIDE) begin
        o_crossed = 1'b1;
        o_next    = (i_mode == MODE_SAT) ? LP_MAX : (i_count + w_step_n - LP_MOD);
      end else begin
        o_next = i_count + w_step_n;
      end
    end else begin
      if (w_step_wide > w_count_wide) begin
        o_crossed = 1'b1;
        o_next    = (i_mode == MODE_SAT) ? '0 : (i_count + LP_MOD - w_step_n);
      end else begin
        o_next = i_count - w_step_n;
      end
    end
  end

endmodule

// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with load, wrap/saturate bounds and wrap/sticky/limit flags.
// Latency: counter_out/wrap/ovf_sticky 1 cycle after inputs sampled; at_max/at_min 0 cycles from counter_out.
// Backpressure: none; a command is consumed every cycle.
// Ports: i_clk, i_rst (sync, active-high); io_bus (slave modport) carries commands and status.
module updown_counter_gen
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int STEP_W    = 4,
  parameter int SATURATE  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  updown_counter_gen_if.slave  io_bus
);

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_COUNT);
  localparam mode_e            LP_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  // A step larger than the range would make a single modulo wrap ambiguous.
  if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max
    $error("updown_counter_gen: MAX_COUNT must be in 1..2**WIDTH-1");
  end
  if ((2**STEP_W - 1) > MAX_COUNT) begin : g_bad_step
    $error("updown_counter_gen: 2**STEP_W-1 exceeds MAX_COUNT");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sticky;

  logic [WIDTH-1:0] w_next;
  logic             w_crossed;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_wrap_set;

  counter_next_calc #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .STEP_W    (STEP_W)
  ) u_next_calc (
    .i_count     (r_count),
    .i_step      (io_bus.step),
    .i_direction (dir_e'(io_bus.direction)),
    .i_mode      (LP_MODE),
    .o_next      (w_next),
    .o_crossed   (w_crossed)
  );

  assign w_load_clamped = (io_bus.load_value > LP_MAX) ? LP_MAX : io_bus.load_value;
  // Load outranks counting, so a crossing computed in a load cycle is discarded.
  assign w_wrap_set     = io_bus.enable && !io_bus.load && w_crossed;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= '0;
      r_wrap   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if (io_bus.load) begin
        r_count <= w_load_clamped;
      end else if (io_bus.enable) begin
        r_count <= w_next;
      end
      r_wrap <= w_wrap_set;
      // A new wrap beats a simultaneous clear so no event is lost.
      if (w_wrap_set) begin
        r_sticky <= 1'b1;
      end else if (io_bus.clear_flags) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign io_bus.counter_out = r_count;
  assign io_bus.wrap        = r_wrap;
  assign io_bus.ovf_sticky  = r_sticky;
  assign io_bus.at_max      = (r_count == LP_MAX);
  assign io_bus.at_min      = (r_count == '0);

endmodule

// File: tb/tb_updown_counter_gen.sv
// Scoreboard bench for updown_counter_gen: three configurations driven with directed vectors.
// Latency: expectations are checked one edge after each vector is applied.
// Backpressure: n/a.
module tb_updown_counter_gen;

  typedef struct {
    string      name;
    logic [7:0] cnt;
    logic       wrap;
    logic       sticky;
    logic       at_max;
    logic       at_min;
  } exp_t;

  logic clk;
  logic rst0, rst1, rst2;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // u0: default 8-bit wrap; u1: MAX_COUNT=9 wrap; u2: MAX_COUNT=100 saturate.
  updown_counter_gen_if #(.WIDTH(8), .STEP_W(4)) if0 ();
  updown_counter_gen_if #(.WIDTH(8), .STEP_W(3)) if1 ();
  updown_counter_gen_if #(.WIDTH(8), .STEP_W(4)) if2 ();

  updown_counter_gen #(.WIDTH(8), .MAX_COUNT(255), .STEP_W(4), .SATURATE(0)) u0 (
    .i_clk(clk), .i_rst(rst0), .io_bus(if0.slave));
  updown_counter_gen #(.WIDTH(8), .MAX_COUNT(9),   .STEP_W(3), .SATURATE(0)) u1 (
    .i_clk(clk), .i_rst(rst1), .io_bus(if1.slave));
  updown_counter_gen #(.WIDTH(8), .MAX_COUNT(100), .STEP_W(4), .SATURATE(1)) u2 (
    .i_clk(clk), .i_rst(rst2), .io_bus(if2.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_all();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    if0.enable = 1'b0; if0.direction = 1'b1; if0.step = '0; if0.load = 1'b0;
    if0.load_value = '0; if0.clear_flags = 1'b0;
    if1.enable = 1'b0; if1.direction = 1'b1; if1.step = '0; if1.load = 1'b0;
    if1.load_value = '0; if1.clear_flags = 1'b0;
    if2.enable = 1'b0; if2.direction = 1'b1; if2.step = '0; if2.load = 1'b0;
    if2.load_value = '0; if2.clear_flags = 1'b0;
  endtask

  // Apply one vector to DUT d for the next edge and queue its expected outcome.
  task automatic drv(input int d, input logic rst_v, input logic en, input logic dir,
                     input logic [3:0] st, input logic ld, input logic [7:0] lv,
                     input logic clr, input string nm, input logic [7:0] e_cnt,
                     input logic e_w, input logic e_s, input logic e_max, input logic e_min);
    exp_t e;
    @(negedge clk);
    idle_all();
    e.name = nm; e.cnt = e_cnt; e.wrap = e_w; e.sticky = e_s;
    e.at_max = e_max; e.at_min = e_min;
    case (d)
      0: begin
        rst0 = rst_v; if0.enable = en; if0.direction = dir; if0.step = st;
        if0.load = ld; if0.load_value = lv; if0.clear_flags = clr;
        q0.push_back(e);
      end
      1: begin
        rst1 = rst_v; if1.enable = en; if1.direction = dir; if1.step = st[2:0];
        if1.load = ld; if1.load_value = lv; if1.clear_flags = clr;
        q1.push_back(e);
      end
      default: begin
        rst2 = rst_v; if2.enable = en; if2.direction = dir; if2.step = st;
        if2.load = ld; if2.load_value = lv; if2.clear_flags = clr;
        q2.push_back(e);
      end
    endcase
  endtask

  function automatic void chk(input string tag, input exp_t e, input logic [7:0] c,
                              input logic w, input logic s, input logic mx, input logic mn);
    n_tests++;
    if (c !== e.cnt || w !== e.wrap || s !== e.sticky || mx !== e.at_max || mn !== e.at_min) begin
      n_fail++;
      $display("FAIL %s/%s: got cnt=%0d wrap=%b sticky=%b max=%b min=%b, expected cnt=%0d wrap=%b sticky=%b max=%b min=%b",
               tag, e.name, c, w, s, mx, mn, e.cnt, e.wrap, e.sticky, e.at_max, e.at_min);
    end
  endfunction

  // Monitor: every edge is an output beat; pop and compare whatever was queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("u0", e, if0.counter_out, if0.wrap, if0.ovf_sticky, if0.at_max, if0.at_min);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("u1", e, if1.counter_out, if1.wrap, if1.ovf_sticky, if1.at_max, if1.at_min);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("u2", e, if2.counter_out, if2.wrap, if2.ovf_sticky, if2.at_max, if2.at_min);
      end
    end
  end

  initial begin
    idle_all();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

    // Default 8-bit wrap counter.          d rst en dir st ld lv  clr name           cnt w s mx mn
    drv(0, 1, 1, 1, 3, 0, 0,   0, "rst_a",         0, 0, 0, 0, 1);
    drv(0, 1, 1, 1, 3, 0, 0,   0, "rst_b",         0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 0, 1, 250, 0, "load250",     250, 0, 0, 0, 0);
    drv(0, 0, 1, 1, 3, 0, 0,   0, "up3",         253, 0, 0, 0, 0);
    drv(0, 0, 1, 1, 3, 0, 0,   0, "up3_wrap",      0, 1, 1, 0, 1);
    drv(0, 0, 0, 1, 0, 0, 0,   0, "wrap_drop",     0, 0, 1, 0, 1);
    drv(0, 0, 1, 1, 5, 1, 100, 0, "load_beats_en", 100, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      drv(0, 0, 0, 1, 5, 0, 0, 0, "hold_en0",    100, 0, 1, 0, 0);
    drv(0, 0, 1, 1, 0, 0, 0,   0, "step0",       100, 0, 1, 0, 0);
    drv(0, 0, 1, 0, 4, 0, 0,   0, "down4",        96, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 1, 255, 0, "load255",     255, 0, 1, 1, 0);
    drv(0, 0, 1, 1, 1, 0, 0,   0, "up1_wrap",      0, 1, 1, 0, 1);
    drv(0, 0, 0, 1, 0, 0, 0,   1, "clr_alone",     0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 0, 1, 254, 0, "load254",     254, 0, 0, 0, 0);
    drv(0, 0, 1, 1, 3, 0, 0,   1, "wrap_and_clr",  1, 1, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 0,   1, "clr_only",      1, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 1, 250, 0, "load250b",    250, 0, 0, 0, 0);
    drv(0, 0, 1, 1, 7, 0, 0,   0, "up7_wrap",      1, 1, 1, 0, 0);
    drv(0, 0, 1, 1, 15, 0, 0,  0, "up15",         16, 0, 1, 0, 0);
    drv(0, 0, 1, 1, 15, 0, 0,  0, "up15b",        31, 0, 1, 0, 0);
    drv(0, 0, 1, 1, 6, 0, 0,   0, "up6_to37",     37, 0, 1, 0, 0);
    drv(0, 1, 1, 1, 3, 1, 99,  0, "rst_mid",       0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 0, 0, 0,   0, "after_rst",     0, 0, 0, 0, 1);
    drv(0, 0, 1, 0, 1, 0, 0,   0, "down1_wrap",  255, 1, 1, 1, 0);

    // MAX_COUNT=9, wrap.
    drv(1, 1, 0, 1, 0, 0, 0,   0, "rst",           0, 0, 0, 0, 1);
    drv(1, 0, 0, 1, 0, 1, 2,   0, "load2",         2, 0, 0, 0, 0);
    drv(1, 0, 1, 0, 5, 0, 0,   0, "down5_wrap",    7, 1, 1, 0, 0);
    drv(1, 0, 0, 1, 0, 1, 12,  0, "load12_clamp",  9, 0, 1, 1, 0);
    drv(1, 0, 1, 1, 1, 0, 0,   0, "up1_wrap",      0, 1, 1, 0, 1);
    drv(1, 0, 1, 0, 7, 0, 0,   0, "down7_wrap",    3, 1, 1, 0, 0);
    drv(1, 0, 1, 1, 6, 0, 0,   0, "up6_to_max",    9, 0, 1, 1, 0);
    drv(1, 0, 1, 1, 7, 0, 0,   0, "up7_wrap",      6, 1, 1, 0, 0);

    // MAX_COUNT=100, saturate.
    drv(2, 1, 0, 1, 0, 0, 0,   0, "rst",           0, 0, 0, 0, 1);
    drv(2, 0, 0, 1, 0, 1, 98,  0, "load98",       98, 0, 0, 0, 0);
    drv(2, 0, 1, 1, 5, 0, 0,   0, "up5_clamp",   100, 1, 1, 1, 0);
    drv(2, 0, 1, 1, 5, 0, 0,   0, "up5_at_max",  100, 1, 1, 1, 0);
    drv(2, 0, 1, 1, 0, 0, 0,   0, "step0_at_max", 100, 0, 1, 1, 0);
    drv(2, 0, 0, 1, 0, 1, 3,   0, "load3",         3, 0, 1, 0, 0);
    drv(2, 0, 1, 0, 7, 0, 0,   0, "down7_clamp",   0, 1, 1, 0, 1);
    drv(2, 0, 1, 0, 1, 0, 0,   0, "down1_at_min",  0, 1, 1, 0, 1);
    drv(2, 0, 0, 1, 0, 0, 0,   1, "clr",           0, 0, 0, 0, 1);
    drv(2, 0, 1, 1, 2, 0, 0,   0, "up2",           2, 0, 0, 0, 0);
    drv(2, 0, 0, 1, 0, 1, 200, 0, "load200_clamp", 100, 0, 0, 1, 0);
    drv(2, 0, 1, 0, 15, 0, 0,  0, "down15",       85, 0, 0, 0, 0);

    @(negedge clk);
    idle_all();
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
